// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port (debug/data/fetch) arbiter in front of a single-port 256x8 RAM.
//   clk, rst                 clock and asynchronous active-high reset
//   req, we, addr, wdata     per-port requests; port n uses bit n and byte [8n+7:8n]
//   gnt                      one-hot or zero combinational grant
//   rvalid, rdata            registered per-port read strobe and shared read data
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   RAM side (1-cycle read latency)
//   starved                  fetch currently holds promoted priority
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [23:0] addr,
    input  logic [23:0] wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [7:0]  rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        starved
);
    logic [2:0] cnt;
    assign starved = cnt == 3'(STARVE_LIMIT);
    always_comb begin
        // debug always wins; a starved fetch jumps ahead of data
        gnt = rst ? 3'b000 :
              req[0] ? 3'b001 :
              (starved && req[2]) ? 3'b100 :
              req[1] ? 3'b010 :
              req[2] ? 3'b100 : 3'b000;
        mem_en    = |gnt;
        mem_we    = |(gnt & we);
        mem_addr  = gnt[2] ? addr[23:16] : gnt[1] ? addr[15:8] : gnt[0] ? addr[7:0] : 8'h00;
        mem_wdata = gnt[2] ? wdata[23:16] : gnt[1] ? wdata[15:8] : gnt[0] ? wdata[7:0] : 8'h00;
        rdata     = |rvalid ? mem_rdata : 8'h00;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            rvalid <= 3'b000;
        end else begin
            rvalid <= gnt & ~we;
            cnt    <= (!req[2] || gnt[2]) ? 3'd0 : starved ? cnt : cnt + 3'd1;
        end
    end
endmodule
